// File: rtl/trace_record_buffer_pkg.sv
// Shared types for the trace record buffer.
// Provides the overflow policy enum and a port-width helper.
package trace_record_buffer_pkg;

  typedef enum logic {
    DROP_NEWEST      = 1'b0,
    OVERWRITE_OLDEST = 1'b1
  } trace_full_policy_e;

  // Width of fill_level: FIFO entries plus the output register.
  function automatic int trace_fill_width(input int depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/trace_record_buffer_fifo.sv
// Generic DEPTH x T circular FIFO for stamped trace records.
// Ports: push/pop/flush, evict (pop+push when full, rewriting the
// new head with fix), head/second views, full/empty/count status.
module trace_record_buffer_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   evict,
  input  logic                   flush,
  input  T                       wdata,
  input  T                       fix,
  output T                       head,
  output T                       second,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd1;

  assign rd1    = rd + 1'b1;
  assign head   = mem[rd];
  assign second = mem[rd1];
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push | evict) wr <= wr + 1'b1;
      if (pop | evict)  rd <= rd + 1'b1;
      if (push & ~pop)
        count <= count + 1'b1;
      else if (pop & ~push)
        count <= count - 1'b1;
    end
  end

  // When full, wr == rd, so the new record and the rewritten
  // successor of the evicted head land in different slots.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push | evict) mem[wr] <= wdata;
      if (evict)        mem[rd1] <= fix;
    end
  end

endmodule

// File: rtl/trace_record_buffer.sv
// Timestamps, sequence-numbers and buffers WB-stage trace records.
// In: rec_* capture, enable, flush, trace_ready. Out: trace_* record,
// fill_level, sticky overflow. FIFO of DEPTH plus one output register.
module trace_record_buffer
  import trace_record_buffer_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int DEPTH            = 8,
  parameter int COUNTER_WIDTH    = 32,
  parameter int SEQ_WIDTH        = 16,
  parameter int DROP_WIDTH       = 8,
  parameter int FULL_POLICY      = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              flush,
  input  logic                              rec_valid,
  input  logic [INSTR_ADDR_WIDTH-1:0]       rec_addr,
  input  logic [INSTR_DATA_WIDTH-1:0]       rec_data,
  input  logic                              rec_is_mem,
  output logic                              trace_valid,
  input  logic                              trace_ready,
  output logic [INSTR_ADDR_WIDTH-1:0]       trace_addr,
  output logic [INSTR_DATA_WIDTH-1:0]       trace_data,
  output logic                              trace_is_mem,
  output logic [COUNTER_WIDTH-1:0]          trace_timestamp,
  output logic [SEQ_WIDTH-1:0]              trace_seq,
  output logic [DROP_WIDTH-1:0]             trace_dropped,
  output logic [trace_fill_width(DEPTH)-1:0] fill_level,
  output logic                              overflow
);

  localparam int DW  = DROP_WIDTH;
  localparam int FLW = trace_fill_width(DEPTH);
  localparam trace_full_policy_e POLICY =
    trace_full_policy_e'(FULL_POLICY[0]);

  typedef struct packed {
    logic [INSTR_ADDR_WIDTH-1:0] addr;
    logic [INSTR_DATA_WIDTH-1:0] data;
    logic                        is_mem;
    logic [COUNTER_WIDTH-1:0]    timestamp;
    logic [SEQ_WIDTH-1:0]        seq;
    logic [DW-1:0]               dropped;
  } trace_stamped_t;

  function automatic logic [DW-1:0] sat_sum(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW+1:0] s;
    s = {2'b00, a} + {2'b00, b} + 1'b1;
    return (s > {2'b00, {DW{1'b1}}}) ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  logic [COUNTER_WIDTH-1:0] cyc;
  logic [SEQ_WIDTH-1:0]     seq_ctr;
  logic [DW-1:0]            drop_cnt;
  logic                     out_valid;
  trace_stamped_t           out_rec;

  trace_stamped_t new_rec;
  trace_stamped_t fix;
  trace_stamped_t f_head;
  trace_stamped_t f_second;
  logic f_full;
  logic f_empty;
  logic [$clog2(DEPTH):0] f_count;

  logic hs, cap, out_free, load_fifo, load_cap;
  logic drop, f_evict, lose_new, f_push;

  always_comb begin
    hs        = out_valid & trace_ready;
    cap       = rec_valid & enable & ~flush;
    out_free  = ~out_valid | hs;
    load_fifo = out_free & ~f_empty;
    load_cap  = out_free & f_empty & cap;
    drop      = cap & ~out_free & f_full;
    f_evict   = drop & (POLICY == OVERWRITE_OLDEST);
    lose_new  = drop & (POLICY == DROP_NEWEST);
    f_push    = cap & ~load_cap & ~drop;
    new_rec   = '{addr:      rec_addr,
                  data:      rec_data,
                  is_mem:    rec_is_mem,
                  timestamp: cyc,
                  seq:       seq_ctr,
                  dropped:   drop_cnt};
    // The successor of an evicted head inherits its loss count.
    fix         = f_second;
    fix.dropped = sat_sum(drop_cnt, f_head.dropped);
  end

  trace_record_buffer_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_stamped_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (f_push),
    .pop    (load_fifo),
    .evict  (f_evict),
    .flush  (flush),
    .wdata  (new_rec),
    .fix    (fix),
    .head   (f_head),
    .second (f_second),
    .full   (f_full),
    .empty  (f_empty),
    .count  (f_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc       <= '0;
      seq_ctr   <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_rec   <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
        drop_cnt  <= '0;
        overflow  <= 1'b0;
      end else begin
        if (cap) seq_ctr <= seq_ctr + 1'b1;
        if (load_fifo) begin
          out_rec   <= f_head;
          out_valid <= 1'b1;
        end else if (load_cap) begin
          out_rec   <= new_rec;
          out_valid <= 1'b1;
        end else if (hs) begin
          out_valid <= 1'b0;
        end
        if (lose_new) begin
          drop_cnt <= sat_sum(drop_cnt, '0);
          overflow <= 1'b1;
        end else if (f_evict) begin
          drop_cnt <= '0;
          overflow <= 1'b1;
        end else if (load_cap | f_push) begin
          drop_cnt <= '0;
        end
      end
    end
  end

  assign trace_valid     = out_valid;
  assign trace_addr      = out_rec.addr;
  assign trace_data      = out_rec.data;
  assign trace_is_mem    = out_rec.is_mem;
  assign trace_timestamp = out_rec.timestamp;
  assign trace_seq       = out_rec.seq;
  assign trace_dropped   = out_rec.dropped;
  assign fill_level      = FLW'(f_count) + FLW'(out_valid);

endmodule

// File: tb/tb_trace_record_buffer.sv
// Scoreboard bench for trace_record_buffer.
// Two instances share stimulus: drop-newest (4-bit counter) and overwrite-oldest.
module tb_trace_record_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic rec_valid = 1'b0;
  logic rec_is_mem = 1'b0;
  logic trace_ready = 1'b0;
  logic [31:0] rec_addr = '0;
  logic [31:0] rec_data = '0;

  logic va, ma, oa;
  logic [31:0] aa, da;
  logic [3:0] ta;
  logic [15:0] sa;
  logic [7:0] dra;
  logic [4:0] fa;

  logic vb, mb, ob;
  logic [31:0] ab, db, tb;
  logic [15:0] sb;
  logic [7:0] drb;
  logic [4:0] fb;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_mem;
    logic [31:0] ts;
    logic [15:0] seq;
    logic [7:0]  drop;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int seq = 0;

  always #5 clk = ~clk;

  trace_record_buffer #(
    .DEPTH(8), .COUNTER_WIDTH(4), .FULL_POLICY(0)
  ) ua (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .rec_valid(rec_valid), .rec_addr(rec_addr),
    .rec_data(rec_data), .rec_is_mem(rec_is_mem),
    .trace_valid(va), .trace_ready(trace_ready),
    .trace_addr(aa), .trace_data(da), .trace_is_mem(ma),
    .trace_timestamp(ta), .trace_seq(sa), .trace_dropped(dra),
    .fill_level(fa), .overflow(oa)
  );

  trace_record_buffer #(
    .DEPTH(8), .COUNTER_WIDTH(32), .FULL_POLICY(1)
  ) ub (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .rec_valid(rec_valid), .rec_addr(rec_addr),
    .rec_data(rec_data), .rec_is_mem(rec_is_mem),
    .trace_valid(vb), .trace_ready(trace_ready),
    .trace_addr(ab), .trace_data(db), .trace_is_mem(mb),
    .trace_timestamp(tb), .trace_seq(sb), .trace_dropped(drb),
    .fill_level(fb), .overflow(ob)
  );

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t g;
    exp_t e;
    if (!rst && va && trace_ready) begin
      g = '{aa, da, ma, 32'(ta), sa, dra};
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL mon_a: unexpected record seq=%0d", sa);
      end else begin
        e = qa.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL mon_a: got %h want %h", g, e);
        end
      end
    end
    if (!rst && vb && trace_ready) begin
      g = '{ab, db, mb, tb, sb, drb};
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL mon_b: unexpected record seq=%0d", sb);
      end else begin
        e = qb.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL mon_b: got %h want %h", g, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input bit pa, input bit pb,
                      input int dra_e, input int drb_e);
    exp_t e;
    e.addr   = a;
    e.data   = ~a;
    e.is_mem = a[4];
    e.seq    = 16'(seq);
    if (pa) begin
      e.ts   = 32'(cyc % 16);
      e.drop = 8'(dra_e);
      qa.push_back(e);
    end
    if (pb) begin
      e.ts   = 32'(cyc);
      e.drop = 8'(drb_e);
      qb.push_back(e);
    end
    rec_valid  = 1'b1;
    rec_addr   = a;
    rec_data   = ~a;
    rec_is_mem = a[4];
    seq++;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic do_reset();
    chk("qa_left", 64'(qa.size()), 0);
    chk("qb_left", 64'(qb.size()), 0);
    rst = 1'b1;
    rec_valid = 1'b0;
    flush = 1'b0;
    trace_ready = 1'b0;
    enable = 1'b1;
    tick();
    chk("rst_valid", {va, vb}, 0);
    chk("rst_fill", {fa, fb}, 0);
    chk("rst_ovf", {oa, ob}, 0);
    chk("rst_rec_a", {sa, ta, dra, aa}, 0);
    chk("rst_rec_b", {sb, drb, tb}, 0);
    seq = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((fa != 0 || fb != 0) && n < 50) begin
      tick();
      n++;
    end
    chk("drain", {fa, fb}, 0);
  endtask

  initial begin
    // Single record latency and stamping
    do_reset();
    trace_ready = 1'b1;
    while (cyc != 5) tick();
    send(32'h100, 1, 1, 0, 0);
    chk("t1_valid", {va, vb}, 2'b11);
    chk("t1_fill", {fa, fb}, {5'd1, 5'd1});
    repeat (3) tick();
    chk("t1_idle", {va, vb}, 0);

    // 12 records into a stalled buffer: drop vs overwrite
    do_reset();
    for (int k = 0; k < 12; k++)
      send(32'h200 + 32'(k * 4), k <= 8, (k == 0) || (k >= 4),
           0, (k == 4) ? 3 : 0);
    chk("t2_fill", {fa, fb}, {5'd9, 5'd9});
    chk("t2_ovf", {oa, ob}, 2'b11);
    trace_ready = 1'b1;
    wait_empty();
    chk("t2_ovf_sticky", {oa, ob}, 2'b11);
    send(32'h300, 1, 1, 3, 0);
    wait_empty();

    // Flush with 5 held and a record presented
    trace_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send(32'h380 + 32'(k * 4), 0, 0, 0, 0);
    chk("t5_fill_pre", {fa, fb}, {5'd5, 5'd5});
    flush = 1'b1;
    rec_valid = 1'b1;
    rec_addr = 32'h400;
    tick();
    flush = 1'b0;
    rec_valid = 1'b0;
    chk("t5_valid", {va, vb}, 0);
    chk("t5_fill", {fa, fb}, 0);
    chk("t5_ovf", {oa, ob}, 0);
    trace_ready = 1'b1;
    send(32'h500, 1, 1, 0, 0);
    wait_empty();

    // Full buffer with simultaneous pop and push
    do_reset();
    for (int k = 0; k < 9; k++)
      send(32'h600 + 32'(k * 4), 1, 1, 0, 0);
    chk("t4_fill_pre", {fa, fb}, {5'd9, 5'd9});
    trace_ready = 1'b1;
    send(32'h640, 1, 1, 0, 0);
    chk("t4_fill", {fa, fb}, {5'd9, 5'd9});
    chk("t4_ovf", {oa, ob}, 0);
    wait_empty();

    // Timestamp wrap on the 4-bit counter, enable gating
    do_reset();
    trace_ready = 1'b1;
    while (cyc != 15) tick();
    send(32'h700, 1, 1, 0, 0);
    send(32'h710, 1, 1, 0, 0);
    enable = 1'b0;
    rec_valid = 1'b1;
    rec_addr = 32'h720;
    tick();
    rec_valid = 1'b0;
    enable = 1'b1;
    chk("t6_gated", {va, vb, fa, fb}, 0);
    send(32'h730, 1, 1, 0, 0);
    wait_empty();
    repeat (2) tick();
    chk("end_qa", 64'(qa.size()), 0);
    chk("end_qb", 64'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
